// File: rtl/gerador_piscadas.sv
// LED blink generator: one visible blink per event flag, with overlapping events queued and replayed.
// Define LED_ATIVO_BAIXO_EN for an active-low LED pin (0 = lit).
module gerador_piscadas #(
  parameter int T_ON     = 25000000,
  parameter int T_OFF    = 25000000,
  parameter int MAX_PEND = 15,
  parameter int W_CNT    = 25,
  parameter int W_PEND   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flag_evento,
  output logic              led,
  output logic              ocupado,
  output logic [W_PEND-1:0] pendentes
);

`ifdef LED_ATIVO_BAIXO_EN
  localparam logic LED_LIT  = 1'b0;
  localparam logic LED_DARK = 1'b1;
`else
  localparam logic LED_LIT  = 1'b1;
  localparam logic LED_DARK = 1'b0;
`endif

  localparam logic [W_CNT-1:0]  ON_LAST  = W_CNT'(T_ON - 1);
  localparam logic [W_CNT-1:0]  OFF_LAST = W_CNT'(T_OFF - 1);
  localparam logic [W_PEND-1:0] PEND_MAX = W_PEND'(MAX_PEND);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic [W_CNT-1:0]  r_timer, w_timer_next;
  logic [W_PEND-1:0] r_pend, w_pend_next;
  logic              r_led, r_ocupado;
  logic              w_accept;
  logic [W_PEND-1:0] w_pend_inc;

  // An event arriving while the queue is full is dropped, even on a consume edge.
  assign w_accept   = flag_evento && (r_pend != PEND_MAX);
  assign w_pend_inc = r_pend + {{(W_PEND-1){1'b0}}, w_accept};

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_pend_next  = r_pend;
    unique case (r_state)
      IDLE: begin
        if (flag_evento) begin
          w_state_next = ON;
          w_timer_next = '0;
        end
      end
      ON: begin
        w_pend_next = w_pend_inc;
        if (r_timer == ON_LAST) begin
          w_state_next = OFF;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + W_CNT'(1);
        end
      end
      OFF: begin
        if (r_timer == OFF_LAST) begin
          w_timer_next = '0;
          if (r_pend != '0) begin
            w_state_next = ON;
            w_pend_next  = w_pend_inc - W_PEND'(1);
          end else if (flag_evento) begin
            w_state_next = ON;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_timer_next = r_timer + W_CNT'(1);
          w_pend_next  = w_pend_inc;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_timer_next = '0;
        w_pend_next  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_pend    <= '0;
      r_led     <= LED_DARK;
      r_ocupado <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_pend    <= w_pend_next;
      r_led     <= (w_state_next == ON) ? LED_LIT : LED_DARK;
      r_ocupado <= (w_state_next != IDLE);
    end
  end

  assign led       = r_led;
  assign ocupado   = r_ocupado;
  assign pendentes = r_pend;

endmodule
